// File: rtl/clz_normalize_pkg.sv
// Shared constants for the clz_normalize datapath slice.
package clz_normalize_pkg;
  localparam int DEF_WIDTH = 16;
endpackage

// File: rtl/clz_normalize_clz.sv
// Leading-zero counter: counts zeros above the leading one of a 2*half_bits_in word.
module clz #(
  parameter int half_bits_in = 8,
  localparam int W  = 2 * half_bits_in,
  localparam int CW = $clog2(W)
) (
  input  logic [W-1:0]  data,
  output logic [CW-1:0] cnt,
  output logic          valid
);

  // Scan upward so the highest set bit is the last to write cnt.
  always_comb begin
    cnt   = '0;
    valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (data[i]) begin
        cnt   = CW'(W - 1 - i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clz_normalize.sv
// Two-stage normaliser: left-justifies an unsigned word and reports its leading-one index.
module clz_normalize
  import clz_normalize_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int EXP_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mant,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_zero
);

  logic             stall;
  logic [EXP_W-1:0] lz_in;
  logic             nz_in;

  logic             valid_a, valid_b;
  logic [WIDTH-1:0] data_a, mant_b;
  logic [EXP_W-1:0] lz_a, exp_b;
  logic             zero_a, zero_b;

  logic [WIDTH-1:0] shl [EXP_W+1];
  logic [EXP_W-1:0] exp_a;

  clz #(.half_bits_in(WIDTH / 2)) u_clz (
    .data  (in_data),
    .cnt   (lz_in),
    .valid (nz_in)
  );

  assign stall    = valid_b & ~out_ready;
  assign in_ready = ~stall;

  assign shl[0] = data_a;
  for (genvar k = 0; k < EXP_W; k++) begin : g_shift
    assign shl[k+1] = lz_a[k] ? (shl[k] << (2 ** k)) : shl[k];
  end

  // A zero word has no leading one; force the index to 0 rather than WIDTH-1-lz.
  assign exp_a = zero_a ? '0 : (EXP_W'(WIDTH - 1) - lz_a);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_a <= 1'b0;
      data_a  <= '0;
      lz_a    <= '0;
      zero_a  <= 1'b0;
      valid_b <= 1'b0;
      mant_b  <= '0;
      exp_b   <= '0;
      zero_b  <= 1'b0;
    end else if (!stall) begin
      valid_a <= in_valid;
      data_a  <= in_data;
      lz_a    <= lz_in;
      zero_a  <= ~nz_in;
      valid_b <= valid_a;
      mant_b  <= shl[EXP_W];
      exp_b   <= exp_a;
      zero_b  <= zero_a;
    end
  end

  assign out_valid = valid_b;
  assign out_mant  = mant_b;
  assign out_exp   = exp_b;
  assign out_zero  = zero_b;

endmodule

// File: tb/tb_clz_normalize.sv
// Directed self-checking bench for clz_normalize at WIDTH=16.
module tb_clz_normalize;
  localparam int WIDTH = 16;
  localparam int EXP_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_mant;
  logic [EXP_W-1:0] out_exp;
  logic             out_zero;

  int pass_cnt  = 0;
  int total_cnt = 0;

  clz_normalize #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_mant !== 16'h0000) $display("FAIL reset_out_mant got %h want 0000", out_mant); else pass_cnt++;
    total_cnt++; if (out_exp !== 4'd0) $display("FAIL reset_out_exp got %0d want 0", out_exp); else pass_cnt++;
    total_cnt++; if (out_zero !== 1'b0) $display("FAIL reset_out_zero got %b want 0", out_zero); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [15:0] vin   [5] = '{16'h0001, 16'h8000, 16'h00F3, 16'h0A00, 16'h0000};
    logic [15:0] vmant [5] = '{16'h8000, 16'h8000, 16'hF300, 16'hA000, 16'h0000};
    logic [3:0]  vexp  [5] = '{4'd0, 4'd15, 4'd7, 4'd11, 4'd0};
    logic        vzero [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = vin[i];
      step();
      in_valid = 1'b0;
      in_data  = 16'h5555;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL single_early[%0d] out_valid got %b want 0", i, out_valid); else pass_cnt++;
      step();
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL single_valid[%0d] got %b want 1", i, out_valid); else pass_cnt++;
      total_cnt++; if (out_mant !== vmant[i]) $display("FAIL single_mant[%0d] in=%h got %h want %h", i, vin[i], out_mant, vmant[i]); else pass_cnt++;
      total_cnt++; if (out_exp !== vexp[i]) $display("FAIL single_exp[%0d] in=%h got %0d want %0d", i, vin[i], out_exp, vexp[i]); else pass_cnt++;
      total_cnt++; if (out_zero !== vzero[i]) $display("FAIL single_zero[%0d] in=%h got %b want %b", i, vin[i], out_zero, vzero[i]); else pass_cnt++;
      step();
    end
  endtask

  task automatic test_back_to_back();
    int recv  = 0;
    int first = -1;
    int last  = -1;
    bit gap   = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      in_valid = (c < 16);
      in_data  = (c < 16) ? (16'h0001 << c) : 16'h0000;
      #1;
      if (out_valid && out_ready) begin
        if (first < 0) first = c;
        if (last >= 0 && c != last + 1) gap = 1'b1;
        last = c;
        total_cnt++; if (out_exp !== EXP_W'(recv) || out_mant !== 16'h8000 || out_zero !== 1'b0)
          $display("FAIL b2b_result[%0d] got mant=%h exp=%0d zero=%b want mant=8000 exp=%0d zero=0", recv, out_mant, out_exp, out_zero, recv);
        else pass_cnt++;
        recv++;
      end
      step();
    end
    in_valid = 1'b0;
    total_cnt++; if (recv !== 16) $display("FAIL b2b_count got %0d want 16", recv); else pass_cnt++;
    total_cnt++; if (first !== 2) $display("FAIL b2b_latency first result at cycle %0d want 2", first); else pass_cnt++;
    total_cnt++; if (gap !== 1'b0) $display("FAIL b2b_gap got gap=%b want 0", gap); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [15:0] win   [6] = '{16'h0003, 16'h0040, 16'h1234, 16'h0007, 16'hFFFF, 16'h0100};
    logic [15:0] wmant [6] = '{16'hC000, 16'h8000, 16'h91A0, 16'hE000, 16'hFFFF, 16'h8000};
    logic [3:0]  wexp  [6] = '{4'd1, 4'd6, 4'd12, 4'd2, 4'd15, 4'd8};
    int sent = 0;
    int recv = 0;
    bit saw_block = 1'b0;
    bit prev_stall = 1'b0;
    bit unstable = 1'b0;
    logic [15:0] snap_mant;
    logic [3:0]  snap_exp;
    int c = 0;
    while (recv < 6 && c < 40) begin
      out_ready = !(c >= 3 && c <= 8);
      in_valid  = (sent < 6);
      in_data   = (sent < 6) ? win[sent] : 16'h0000;
      #1;
      if (!in_ready) begin
        saw_block = 1'b1;
        if ((sent - recv) !== 2) unstable = 1'b1;
      end
      if (out_valid && !out_ready) begin
        if (prev_stall && (out_mant !== snap_mant || out_exp !== snap_exp)) unstable = 1'b1;
        snap_mant = out_mant;
        snap_exp  = out_exp;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        total_cnt++; if (out_mant !== wmant[recv] || out_exp !== wexp[recv] || out_zero !== 1'b0)
          $display("FAIL bp_result[%0d] got mant=%h exp=%0d zero=%b want mant=%h exp=%0d zero=0", recv, out_mant, out_exp, out_zero, wmant[recv], wexp[recv]);
        else pass_cnt++;
        recv++;
      end
      if (in_valid && in_ready) sent++;
      step();
      c++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total_cnt++; if (recv !== 6) $display("FAIL bp_count got %0d want 6", recv); else pass_cnt++;
    total_cnt++; if (saw_block !== 1'b1) $display("FAIL bp_in_ready_drop got %b want 1", saw_block); else pass_cnt++;
    total_cnt++; if (unstable !== 1'b0) $display("FAIL bp_stall_stable got unstable=%b want 0", unstable); else pass_cnt++;
    step(); step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_no_duplicate out_valid got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0011;
    step();
    in_data = 16'h0022;
    step();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready got %b want 1", in_ready); else pass_cnt++;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h0A00;
    step();
    in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_mid_stale got out_valid=%b want 0", out_valid); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b1 || out_mant !== 16'hA000 || out_exp !== 4'd11)
      $display("FAIL rst_mid_next got valid=%b mant=%h exp=%0d want valid=1 mant=a000 exp=11", out_valid, out_mant, out_exp);
    else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_mid_drain got out_valid=%b want 0", out_valid); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
